// File: rtl/tnoc_flit_round_robin_arbiter.sv
// tnoc_flit_round_robin_arbiter: packet-granular round-robin merge of N flit sources onto one channel
module tnoc_flit_round_robin_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int FLIT_WIDTH = 64,
    parameter int TYPE_WIDTH = 1
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [REQUESTERS-1:0]            i_valid,
    output logic [REQUESTERS-1:0]            o_ready,
    input  logic [REQUESTERS*FLIT_WIDTH-1:0] i_flit,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [FLIT_WIDTH-1:0]            o_flit,
    output logic [REQUESTERS-1:0]            o_grant,
    output logic                             o_locked,
    output logic                             o_error
);
    localparam int PW = $clog2(REQUESTERS);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;
    logic en, error, found, sel_valid, accept;
    logic [PW-1:0] ptr, owner, winner, sel, sel_next, cand;
    logic [REQUESTERS-1:0] head, tail;
    logic [FLIT_WIDTH-1:0] flits [REQUESTERS];
    int idx;
    for (genvar k = 0; k < REQUESTERS; k++) begin : g_src
        assign flits[k] = i_flit[k*FLIT_WIDTH +: FLIT_WIDTH];
        assign head[k]  = flits[k][TYPE_WIDTH];
        assign tail[k]  = flits[k][TYPE_WIDTH+1];
    end
    // Scan ptr, ptr+1, ... with explicit wrap so N need not be a power of two
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx  = int'(ptr) + i;
            idx  = (idx >= REQUESTERS) ? idx - REQUESTERS : idx;
            cand = PW'(idx);
            if (!found && i_valid[cand] && head[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end
    assign sel       = (state == LOCKED) ? owner : winner;
    assign sel_valid = (state == LOCKED) ? i_valid[sel] : found;
    assign o_valid   = en && sel_valid;
    assign o_grant   = (en && (state == LOCKED || found)) ? REQUESTERS'(1) << sel : '0;
    assign o_ready   = o_grant & {REQUESTERS{i_ready}};
    assign o_flit    = o_valid ? flits[sel] : '0;
    assign o_locked  = en && state == LOCKED;
    assign o_error   = error;
    assign accept    = o_valid && i_ready;
    assign sel_next  = (sel == PW'(REQUESTERS-1)) ? '0 : sel + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            error <= 1'b0;
            en    <= 1'b0;
        end else begin
            en <= 1'b1;
            if (en && state == IDLE && |(i_valid & ~head))
                error <= 1'b1;
            // A stalled head locks too, so the grant cannot move under a pending flit
            if (accept && tail[sel]) begin
                state <= IDLE;
                ptr   <= sel_next;
            end else if (en && state == IDLE && found) begin
                state <= LOCKED;
                owner <= winner;
            end
        end
    end
endmodule
